cntr_cmd_arb: RTL
=================

Name: cntr_cmd_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8-bit load/increment/decrement counter.
- Each requester presents a command (LOAD, INC, DEC) with optional load data. The block grants one requester per issue slot, drives the counter's load/inc/enable strobes for exactly one cycle, and acknowledges the winner.
- Sits between the control units and the counter datapath; the counter's own next-state logic is unchanged.

Parameters:
- WIDTH, 8, width of load data and counter data bus
- GAP, 1, idle cycles inserted after each issue before the next grant (0..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 command valid; held until gnt0
- cmd0  input  2  requester 0 command: 00 NOP, 01 LOAD, 10 INC, 11 DEC
- din0  input  WIDTH  requester 0 load value, used only for LOAD
- req1  input  1  requester 1 command valid; held until gnt1
- cmd1  input  2  requester 1 command, same encoding as cmd0
- din1  input  WIDTH  requester 1 load value
- gnt0  output  1  one-cycle acknowledge to requester 0
- gnt1  output  1  one-cycle acknowledge to requester 1
- cntr_en  output  1  counter advance strobe, one cycle per issued command
- cntr_load  output  1  counter load select, valid with cntr_en
- cntr_inc  output  1  1 = increment, 0 = decrement; valid with cntr_en when cntr_load = 0
- cntr_din  output  WIDTH  counter load data, valid with cntr_en and cntr_load
- nop_err  output  1  one-cycle pulse when a granted command was NOP
- busy  output  1  high in ISSUE and GAP states

Behaviour:
- Reset (synchronous, active-high): state = IDLE, priority pointer = 0, gap counter = 0, all outputs 0, cntr_din = 0.
- States: IDLE, ISSUE, GAP. All outputs are registered.
- IDLE: if any req is high at a clock edge, latch the winner's id, cmd and din, then go to ISSUE.
  - Winner: the only requester asserting req. If both assert, the requester selected by the pointer wins.
  - With no req, stay in IDLE.
- ISSUE (exactly one cycle):
  - gntN = 1 for the latched winner.
  - Outputs by command:
    - LOAD: cntr_en = 1, cntr_load = 1, cntr_din = latched din.
    - INC: cntr_en = 1, cntr_inc = 1.
    - DEC: cntr_en = 1, cntr_inc = 0.
    - NOP: cntr_en = 0, nop_err = 1.
  - Pointer toggles to the loser (the requester that did not win).
  - Next state: GAP if GAP > 0, else IDLE.
- Latency: req high at edge t gives gnt and the strobe in cycle t+1. Back-to-back issues are spaced GAP+2 cycles apart.
- GAP: count GAP cycles with all strobes low, then return to IDLE. Requests arriving during ISSUE or GAP are held by the requester and evaluated in IDLE.
- Requester rule: req stays high and cmd/din stay stable until the gnt cycle. Deasserting req before gnt withdraws the request; a request withdrawn before sampling is never granted. cmd/din are captured at the IDLE sampling edge; later changes do not affect the issued command.
- Fairness: with both requesters continuously asserting, grants alternate 0, 1, 0, 1 starting from the reset pointer. Neither requester waits more than one foreign grant.
- Exclusivity: gnt0 and gnt1 are never high together; cntr_en is never high outside ISSUE.
- Reset mid-operation: reset in ISSUE or GAP forces IDLE on the next edge, with the strobe and gnt low that cycle. The pending request is not granted.
- Arithmetic: the gap counter is 4 bits and saturates at GAP. No wrap-around of counter value is handled here; wrap belongs to the counter datapath.

Decomposition:
- Shared package: command encoding constants (CMD_NOP, CMD_LOAD, CMD_INC, CMD_DEC) and state encoding constants (IDLE = 2'b00, ISSUE = 2'b01, GAP = 2'b10). The counter's controller reuses the same command constants.
- One natural sub-module: rr_pick2, a combinational winner select from (req0, req1, ptr) to (win_valid, win_id). FSM, gap counter and output registers stay in cntr_cmd_arb.

Test Plan:
- Reset, then req0 = 1, cmd0 = LOAD, din0 = 8'h5A (GAP = 1) -> next cycle gnt0 = 1, cntr_en = 1, cntr_load = 1, cntr_din = 8'h5A; then one GAP cycle with busy = 1 and strobes low; then IDLE.
- req0 and req1 both held high with cmd0 = INC and cmd1 = DEC for 12 cycles (GAP = 1) -> grants alternate gnt0, gnt1, gnt0, gnt1 every 3 cycles; cntr_inc pattern 1, 0, 1, 0; never both gnt high.
- req1 = 1, cmd1 = NOP -> gnt1 = 1 and nop_err = 1 in the same cycle, cntr_en = 0; pointer toggles to 0.
- req0 = INC granted, then reset asserted during the following GAP cycle while req1 is pending -> IDLE next edge, outputs 0, pointer 0. After reset release with req1 still high, gnt1 arrives 1 cycle later.
- GAP = 0, req0 = DEC held continuously -> cntr_en pulses every 2 cycles, cntr_inc = 0, gnt0 each pulse.
- req0 = LOAD din0 = 8'h11 sampled, then din0 changed to 8'hFF in the ISSUE cycle -> cntr_din = 8'h11.

Source files
------------

// File: rtl/cntr_cmd_arb_pkg.sv
// cntr_cmd_arb_pkg: shared command and state encodings for the counter arbiter
package cntr_cmd_arb_pkg;
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_INC  = 2'b10;
  localparam logic [1:0] CMD_DEC  = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_GAP   = 2'b10
  } state_t;
endpackage

// File: rtl/cntr_cmd_arb_rr_pick2.sv
// rr_pick2: two-way round-robin winner select
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic win_valid,
  output logic win_id
);
  assign win_valid = req0 | req1;
  assign win_id    = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/cntr_cmd_arb.sv
// cntr_cmd_arb: round-robin command arbiter and strobe sequencer for the shared counter
module cntr_cmd_arb
  import cntr_cmd_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       cmd0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             cntr_en,
  output logic             cntr_load,
  output logic             cntr_inc,
  output logic [WIDTH-1:0] cntr_din,
  output logic             nop_err,
  output logic             busy
);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic [3:0] gap_q, gap_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic en_q, en_d, load_q, load_d, inc_q, inc_d, nop_q, nop_d, busy_q, busy_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic win_valid, win_id, go;
  logic [1:0] win_cmd;
  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .ptr      (ptr_q),
    .win_valid(win_valid),
    .win_id   (win_id)
  );
  assign win_cmd = win_id ? cmd1 : cmd0;
  assign go      = (state_q == ST_IDLE) && win_valid;
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (win_valid ? ST_ISSUE : ST_IDLE)
            : (state_q == ST_ISSUE) ? ((GAP > 0) ? ST_GAP : ST_IDLE)
            : (state_q == ST_GAP && gap_q != GAP_LAST) ? ST_GAP : ST_IDLE;
    gap_d  = (state_q == ST_GAP && state_d == ST_GAP) ? gap_q + 4'd1 : 4'd0;
    ptr_d  = go ? !win_id : ptr_q;
    gnt0_d = go && !win_id;
    gnt1_d = go && win_id;
    en_d   = go && win_cmd != CMD_NOP;
    load_d = go && win_cmd == CMD_LOAD;
    inc_d  = go && win_cmd == CMD_INC;
    nop_d  = go && win_cmd == CMD_NOP;
    din_d  = load_d ? (win_id ? din1 : din0) : din_q;
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      gap_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      inc_q   <= 1'b0;
      nop_q   <= 1'b0;
      busy_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      en_q    <= en_d;
      load_q  <= load_d;
      inc_q   <= inc_d;
      nop_q   <= nop_d;
      busy_q  <= busy_d;
      din_q   <= din_d;
    end
  end
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign cntr_en   = en_q;
  assign cntr_load = load_q;
  assign cntr_inc  = inc_q;
  assign cntr_din  = din_q;
  assign nop_err   = nop_q;
  assign busy      = busy_q;
endmodule
